fifo_read_ctrl: RTL and testbench

Consumer-side controller for the 4-entry byte FIFO on the board. Turns a raw, bouncing read pushbutton into exactly one single-cycle read strobe per press and captures the popped byte into a held display register. Flags presses made while the FIFO is empty and counts successful reads. Sits between the board button/LED pins and the FIFO's read port (read strobe, data out, empty flag).

---
 rtl/fifo_rd_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 58 +++++
 rtl/fifo_read_ctrl.sv | 137 +++++++++++++
 tb/tb_fifo_read_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and defaults for the FIFO read-side controller
// and the board button debouncer.
package fifo_rd_pkg;

   // Read handshake sequence: wait for a press, strobe the FIFO, capture data.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_CAPT = 2'd2
   } rd_state_e;

   localparam int DEF_DATA_W          = 8;
   localparam int DEF_DEBOUNCE_CYCLES = 500000;

   // Width of a counter that must reach n-1 (at least one bit).
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stable-count debouncer and rising-edge
// pulse for a raw pushbutton. Shared by the board read and write buttons.
module btn_debounce
   import fifo_rd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic BTN_RAW,
   output logic PRESS
);

   localparam int CW = cnt_w(DEBOUNCE_CYCLES);

   logic          s_meta;
   logic          s_sync;
   logic          level;
   logic          level_d;
   logic [CW-1:0] cnt;

   // Bring the asynchronous button into the CLK domain.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s_meta <= 1'b0;
         s_sync <= 1'b0;
      end else begin
         s_meta <= BTN_RAW;
         s_sync <= s_meta;
      end
   end

   // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing
   // samples; any agreeing sample restarts the count.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         level <= 1'b0;
         cnt   <= '0;
      end else if (s_sync == level) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         level <= s_sync;
         cnt   <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Delayed copy of the debounced level for edge detection.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) level_d <= 1'b0;
      else        level_d <= level;
   end

   // One-cycle pulse on the 0->1 edge; releases produce nothing.
   assign PRESS = level & ~level_d;

endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: consumer-side controller for the 4-entry byte FIFO.
// Debounced button press -> one RD_REQ strobe -> byte captured into a held
// display register. Flags presses on an empty FIFO, counts good reads.
// Optional feature macro: AUTO_DRAIN_EN (adds AUTO port and periodic reads).
module fifo_read_ctrl
   import fifo_rd_pkg::*;
#(
   parameter int DATA_W          = DEF_DATA_W,
   parameter int CNT_W           = 8,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int AUTO_PERIOD     = 50000000
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              BTN_RAW,
   input  logic              FIFO_EMPTY,
   input  logic [DATA_W-1:0] FIFO_DATA,
   output logic              RD_REQ,
   output logic [DATA_W-1:0] DATA_SHOW,
   output logic              SHOW_VALID,
   output logic              UNDERFLOW,
   output logic [CNT_W-1:0]  READ_CNT
`ifdef AUTO_DRAIN_EN
   ,
   input  logic              AUTO
`endif
);

   rd_state_e         state;
   rd_state_e         state_nxt;
   logic              press;
   logic              evt;
   logic              set_uf;
   logic              capt;
   logic              rd_req_q;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic              uf_q;
   logic [CNT_W-1:0]  cnt_q;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .BTN_RAW (BTN_RAW),
      .PRESS   (press)
   );

`ifdef AUTO_DRAIN_EN
   localparam int AW = cnt_w(AUTO_PERIOD);

   logic [AW-1:0] auto_cnt;
   logic          auto_evt;

   // Periodic read event while auto mode is on and there is data to drain;
   // the count is parked at zero otherwise.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         auto_cnt <= '0;
         auto_evt <= 1'b0;
      end else begin
         auto_evt <= 1'b0;
         if (!AUTO || FIFO_EMPTY) begin
            auto_cnt <= '0;
         end else if (auto_cnt == AW'(AUTO_PERIOD - 1)) begin
            auto_cnt <= '0;
            auto_evt <= 1'b1;
         end else begin
            auto_cnt <= auto_cnt + 1'b1;
         end
      end
   end

   assign evt = press | auto_evt;
`else
   assign evt = press;
`endif

   // State register; the strobe is registered off the next state so it is
   // high exactly while in REQ and drops with reset asynchronously.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= ST_IDLE;
         rd_req_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         rd_req_q <= (state_nxt == ST_REQ);
      end
   end

   // Next state: events are only accepted in IDLE, others are dropped.
   // Only a real button press on an empty FIFO flags underflow.
   always_comb begin
      state_nxt = state;
      set_uf    = 1'b0;
      capt      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (evt) begin
               if (FIFO_EMPTY) set_uf    = press;
               else            state_nxt = ST_REQ;
            end
         end
         ST_REQ:  state_nxt = ST_CAPT;
         ST_CAPT: begin
            capt      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Display, valid, counter and sticky underflow; FIFO_DATA is valid in CAPT.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         uf_q    <= 1'b0;
         cnt_q   <= '0;
      end else if (capt) begin
         data_q  <= FIFO_DATA;
         valid_q <= 1'b1;
         uf_q    <= 1'b0;
         cnt_q   <= cnt_q + 1'b1;
      end else if (set_uf) begin
         uf_q    <= 1'b1;
      end
   end

   assign RD_REQ     = rd_req_q;
   assign DATA_SHOW  = data_q;
   assign SHOW_VALID = valid_q;
   assign UNDERFLOW  = uf_q;
   assign READ_CNT   = cnt_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: directed bench with a small FIFO model on the read port.
module tb_fifo_read_ctrl;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       BTN_RAW = 1'b0;
   logic       FIFO_EMPTY;
   logic [7:0] FIFO_DATA = 8'h00;
   logic       RD_REQ;
   logic [7:0] DATA_SHOW;
   logic       SHOW_VALID;
   logic       UNDERFLOW;
   logic [1:0] READ_CNT;
`ifdef AUTO_DRAIN_EN
   logic       AUTO = 1'b0;
`endif

   int checks = 0;
   int fails  = 0;

   // FIFO model
   logic [7:0] mem [4];
   int         f_wp = 0, f_rp = 0, f_cnt = 0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;

   fifo_read_ctrl #(
      .DATA_W(8), .CNT_W(2), .DEBOUNCE_CYCLES(4), .AUTO_PERIOD(10)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .BTN_RAW    (BTN_RAW),
      .FIFO_EMPTY (FIFO_EMPTY),
      .FIFO_DATA  (FIFO_DATA),
      .RD_REQ     (RD_REQ),
      .DATA_SHOW  (DATA_SHOW),
      .SHOW_VALID (SHOW_VALID),
      .UNDERFLOW  (UNDERFLOW),
      .READ_CNT   (READ_CNT)
`ifdef AUTO_DRAIN_EN
      ,
      .AUTO       (AUTO)
`endif
   );

   always #5 CLK = ~CLK;

   assign FIFO_EMPTY = (f_cnt == 0);

   always @(posedge CLK) begin
      if (wr_en && f_cnt < 4) begin
         mem[f_wp] <= wr_data;
         f_wp      <= (f_wp + 1) % 4;
      end
      if (RD_REQ && f_cnt > 0) begin
         FIFO_DATA <= mem[f_rp];
         f_rp      <= (f_rp + 1) % 4;
      end
      f_cnt <= f_cnt + ((wr_en && f_cnt < 4) ? 1 : 0) - ((RD_REQ && f_cnt > 0) ? 1 : 0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic push(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick(1);
      wr_en   = 1'b0;
   endtask

   // Hold the button for n ticks, counting strobe cycles; then release and settle.
   task automatic press(input int n, output int pulses, output int first);
      pulses = 0;
      first  = -1;
      BTN_RAW = 1'b1;
      for (int i = 1; i <= n; i++) begin
         tick(1);
         if (RD_REQ === 1'b1) begin
            pulses++;
            if (first < 0) first = i;
         end
      end
      BTN_RAW = 1'b0;
      tick(10);
   endtask

   int pulses, first;
   int exp_cnt [5] = '{1, 2, 3, 0, 1};

   initial begin
      // reset state
      #1;
      check("rst_rd_req", RD_REQ, 0);
      check("rst_data", DATA_SHOW, 0);
      check("rst_valid", SHOW_VALID, 0);
      check("rst_uf", UNDERFLOW, 0);
      check("rst_cnt", READ_CNT, 0);
      tick(2);
      RST_N = 1'b1;
      tick(2);

      // clean press, FIFO holding 0xA5: 2 sync + 4 debounce + 1 edge = 7
      push(8'hA5);
      press(20, pulses, first);
      check("clean_pulses", pulses, 1);
      check("clean_latency", first, 7);
      check("clean_data", DATA_SHOW, 8'hA5);
      check("clean_valid", SHOW_VALID, 1);
      check("clean_cnt", READ_CNT, 1);
      check("clean_fifo_empty", FIFO_EMPTY, 1);

      // bouncing button: toggle every 2 cycles for 20 cycles, then hold high
      push(8'h5A);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         BTN_RAW = ~BTN_RAW;
         for (int k = 0; k < 2; k++) begin
            tick(1);
            if (RD_REQ === 1'b1) pulses++;
         end
      end
      BTN_RAW = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (RD_REQ === 1'b1) pulses++;
      end
      BTN_RAW = 1'b0;
      tick(10);
      check("bounce_pulses", pulses, 1);
      check("bounce_data", DATA_SHOW, 8'h5A);
      check("bounce_cnt", READ_CNT, 2);

      // press on empty FIFO
      press(20, pulses, first);
      check("uf_pulses", pulses, 0);
      check("uf_flag", UNDERFLOW, 1);
      check("uf_data_held", DATA_SHOW, 8'h5A);
      check("uf_valid_held", SHOW_VALID, 1);
      check("uf_cnt_held", READ_CNT, 2);

      // refill and press clears underflow
      push(8'h3C);
      check("uf_sticky", UNDERFLOW, 1);
      press(20, pulses, first);
      check("refill_pulses", pulses, 1);
      check("refill_data", DATA_SHOW, 8'h3C);
      check("refill_uf_clr", UNDERFLOW, 0);
      check("refill_cnt", READ_CNT, 3);

      // reset asserted during the REQ cycle
      push(8'h77);
      BTN_RAW = 1'b1;
      tick(7);
      check("req_seen", RD_REQ, 1);
      RST_N = 1'b0;
      BTN_RAW = 1'b0;
      #1;
      check("arst_rd_req", RD_REQ, 0);
      check("arst_data", DATA_SHOW, 0);
      check("arst_valid", SHOW_VALID, 0);
      check("arst_uf", UNDERFLOW, 0);
      check("arst_cnt", READ_CNT, 0);
      tick(2);
      check("arst_fifo_kept", f_cnt, 1);
      RST_N = 1'b1;
      tick(3);
      check("arst_idle", RD_REQ, 0);

      // counter wrap with CNT_W=2: 1,2,3,0,1
      for (int i = 0; i < 5; i++) begin
         if (i > 0) push(8'h40 + 8'(i));
         press(20, pulses, first);
         check("wrap_pulses", pulses, 1);
         check("wrap_cnt", READ_CNT, exp_cnt[i]);
         check("wrap_data", DATA_SHOW, (i == 0) ? 8'h77 : 8'h40 + 8'(i));
      end

`ifdef AUTO_DRAIN_EN
      // auto drain: three reads about 10 cycles apart, then idle
      push(8'h11);
      push(8'h22);
      push(8'h33);
      AUTO = 1'b1;
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (RD_REQ === 1'b1) pulses++;
      end
      AUTO = 1'b0;
      check("auto_pulses", pulses, 3);
      check("auto_data", DATA_SHOW, 8'h33);
      check("auto_uf", UNDERFLOW, 0);
      check("auto_empty", FIFO_EMPTY, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
